// File: rtl/core_data_demux_pkg.sv
// core_data_demux_pkg: target encoding and address constants shared by the data demux
package core_data_demux_pkg;
   typedef enum logic [1:0] {TGT_PERIPH, TGT_STACK, TGT_TCDM, TGT_LOCAL} target_e;
   localparam logic [31:0] STDOUT_ADDR_DEF = 32'h8000_0004;
   localparam logic [31:0] EXIT_ADDR_DEF   = 32'h8000_0000;
   localparam logic [31:0] TCDM_ADDR_MASK  = 32'h00FF_FFFF;
endpackage

// File: rtl/core_data_demux_if.sv
// core_data_demux_if: core data port plus the periph/stack/tcdm target ports of the demux
interface core_data_demux_if;
   logic        data_req, data_gnt, data_rvalid, data_we, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        per_req, per_gnt, per_wen, per_r_valid;
   logic [3:0]  per_be;
   logic [31:0] per_add, per_data, per_r_data;
   logic        stk_req, stk_gnt, stk_wen, stk_r_valid;
   logic [3:0]  stk_be;
   logic [31:0] stk_add, stk_data, stk_r_data;
   logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
   logic [3:0]  tcdm_be;
   logic [31:0] tcdm_add, tcdm_data, tcdm_r_data;
   modport slave (
      input  data_req, data_we, data_be, data_addr, data_wdata,
      output data_gnt, data_rvalid, data_rdata, data_err,
      output per_req, per_add, per_wen, per_be, per_data, input per_gnt, per_r_data, per_r_valid,
      output stk_req, stk_add, stk_wen, stk_be, stk_data, input stk_gnt, stk_r_data, stk_r_valid,
      output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data, input tcdm_gnt, tcdm_r_data, tcdm_r_valid
   );
   modport master (
      output data_req, data_we, data_be, data_addr, data_wdata,
      input  data_gnt, data_rvalid, data_rdata, data_err,
      input  per_req, per_add, per_wen, per_be, per_data, output per_gnt, per_r_data, per_r_valid,
      input  stk_req, stk_add, stk_wen, stk_be, stk_data, output stk_gnt, stk_r_data, stk_r_valid,
      input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data, output tcdm_gnt, tcdm_r_data, tcdm_r_valid
   );
endinterface

// File: rtl/core_data_demux_tracker.sv
// core_data_demux_tracker: outstanding-request count, in-flight target, stall and sticky protocol error
module core_data_demux_tracker
   import core_data_demux_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  target_e    tgt_i,
   input  logic       accept_i,
   input  logic [3:0] rvalid_i,
   output target_e    cur_tgt_o,
   output logic       stall_o,
   output logic       resp_o,
   output logic       protocol_err_o
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
   logic [CW-1:0] cnt_q, cnt_d;
   target_e       cur_tgt_q, cur_tgt_d;
   logic          err_q, err_d, busy;
   logic [3:0]    legal;
   // only the in-flight target may answer; anything else is a protocol violation
   always_comb begin
      busy      = cnt_q != '0;
      legal     = busy ? 4'b0001 << cur_tgt_q : 4'b0000;
      stall_o   = ~rst_ni | (cnt_q == MAX_CNT) | (busy & (tgt_i != cur_tgt_q));
      resp_o    = busy & rvalid_i[cur_tgt_q];
      cnt_d     = cnt_q + CW'(accept_i) - CW'(resp_o);
      cur_tgt_d = accept_i ? tgt_i : cur_tgt_q;
      err_d     = err_q | |(rvalid_i & ~legal);
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         cnt_q     <= '0;
         cur_tgt_q <= TGT_PERIPH;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cur_tgt_q <= cur_tgt_d;
         err_q     <= err_d;
      end
   assign cur_tgt_o      = cur_tgt_q;
   assign protocol_err_o = err_q;
endmodule

// File: rtl/core_data_demux.sv
// core_data_demux: routes the core data port to periph/stack/tcdm with per-target response tracking
// Optional putchar/exit mailbox enabled by CORE_DATA_DEMUX_STDOUT_EN.
module core_data_demux
   import core_data_demux_pkg::*;
#(
   parameter int HWPE_ADDR_BASE_BIT = 20,
`ifdef CORE_DATA_DEMUX_STDOUT_EN
   parameter logic [31:0] STDOUT_ADDR = STDOUT_ADDR_DEF,
   parameter logic [31:0] EXIT_ADDR   = EXIT_ADDR_DEF,
`endif
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   core_data_demux_if.slave   bus,
   output logic               protocol_err_o,
   output logic               stdout_valid_o,
   output logic [7:0]         stdout_char_o,
   output logic               exit_valid_o,
   output logic [31:0]        exit_code_o
);
   target_e tgt, cur_tgt;
   logic    stall, resp, sel_gnt, local_rvalid, go;
   always_comb begin
      tgt = bus.data_addr[HWPE_ADDR_BASE_BIT] ? TGT_PERIPH :
            bus.data_addr[31:24] == 8'h00 ? TGT_STACK :
`ifdef CORE_DATA_DEMUX_STDOUT_EN
            (bus.data_addr == STDOUT_ADDR || bus.data_addr == EXIT_ADDR) ? TGT_LOCAL :
`endif
            TGT_TCDM;
      sel_gnt = tgt == TGT_PERIPH ? bus.per_gnt : tgt == TGT_STACK ? bus.stk_gnt :
                tgt == TGT_TCDM ? bus.tcdm_gnt : 1'b1;
      go              = bus.data_req & ~stall;
      bus.per_req     = go & (tgt == TGT_PERIPH);
      bus.stk_req     = go & (tgt == TGT_STACK);
      bus.tcdm_req    = go & (tgt == TGT_TCDM);
      bus.data_gnt    = go & sel_gnt;
      bus.data_rvalid = resp;
      bus.data_rdata  = !resp ? 32'h0 : cur_tgt == TGT_PERIPH ? bus.per_r_data :
                        cur_tgt == TGT_STACK ? bus.stk_r_data : cur_tgt == TGT_TCDM ? bus.tcdm_r_data : 32'h0;
   end
   assign bus.data_err  = 1'b0;
   assign bus.per_add   = bus.data_addr;
   assign bus.stk_add   = bus.data_addr;
   assign bus.tcdm_add  = bus.data_addr & TCDM_ADDR_MASK;
   assign bus.per_wen   = ~bus.data_we;
   assign bus.stk_wen   = ~bus.data_we;
   assign bus.tcdm_wen  = ~bus.data_we;
   assign bus.per_be    = bus.data_be;
   assign bus.stk_be    = bus.data_be;
   assign bus.tcdm_be   = bus.data_be;
   assign bus.per_data  = bus.data_wdata;
   assign bus.stk_data  = bus.data_wdata;
   assign bus.tcdm_data = bus.data_wdata;
   core_data_demux_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_tracker (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .tgt_i          (tgt),
      .accept_i       (bus.data_gnt),
      .rvalid_i       ({local_rvalid, bus.tcdm_r_valid, bus.stk_r_valid, bus.per_r_valid}),
      .cur_tgt_o      (cur_tgt),
      .stall_o        (stall),
      .resp_o         (resp),
      .protocol_err_o (protocol_err_o)
   );
`ifdef CORE_DATA_DEMUX_STDOUT_EN
   logic        local_q, stdout_valid_q, exit_valid_q, local_acc, stdout_wr, exit_wr;
   logic [7:0]  stdout_char_q;
   logic [31:0] exit_code_q;
   assign local_acc = bus.data_gnt & (tgt == TGT_LOCAL);
   assign stdout_wr = local_acc & bus.data_we & (bus.data_addr == STDOUT_ADDR);
   assign exit_wr   = local_acc & bus.data_we & (bus.data_addr == EXIT_ADDR);
   // mailbox answers one cycle after grant with zero data
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         local_q        <= 1'b0;
         stdout_valid_q <= 1'b0;
         stdout_char_q  <= 8'h0;
         exit_valid_q   <= 1'b0;
         exit_code_q    <= 32'h0;
      end else begin
         local_q        <= local_acc;
         stdout_valid_q <= stdout_wr;
         if (stdout_wr) stdout_char_q <= bus.data_wdata[7:0];
         if (exit_wr) exit_valid_q <= 1'b1;
         if (exit_wr) exit_code_q <= bus.data_wdata;
      end
   assign local_rvalid   = local_q;
   assign stdout_valid_o = stdout_valid_q;
   assign stdout_char_o  = stdout_char_q;
   assign exit_valid_o   = exit_valid_q;
   assign exit_code_o    = exit_code_q;
`else
   assign local_rvalid   = 1'b0;
   assign stdout_valid_o = 1'b0;
   assign stdout_char_o  = 8'h0;
   assign exit_valid_o   = 1'b0;
   assign exit_code_o    = 32'h0;
`endif
endmodule

// File: tb/tb_core_data_demux.sv
// tb_core_data_demux: random core traffic against behavioural slaves, checked by a scoreboard monitor
module tb_core_data_demux;
   localparam int MAXO = 2;
   localparam logic [31:0] STDOUT_A = 32'h8000_0004, EXIT_A = 32'h8000_0000;
   logic clk = 1'b0, rst_n;
   always #5 clk = ~clk;
   core_data_demux_if bus();
   logic        prot_err, so_v, ex_v;
   logic [7:0]  so_c;
   logic [31:0] ex_c;
   core_data_demux #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .protocol_err_o(prot_err),
      .stdout_valid_o(so_v), .stdout_char_o(so_c), .exit_valid_o(ex_v), .exit_code_o(ex_c)
   );
   logic [2:0]  s_gnt, s_rv, s_req, s_wen;
   logic [31:0] s_rd [3], s_add [3], s_dat [3];
   logic [3:0]  s_be [3];
   assign bus.per_gnt = s_gnt[0]; assign bus.stk_gnt = s_gnt[1]; assign bus.tcdm_gnt = s_gnt[2];
   assign bus.per_r_valid = s_rv[0]; assign bus.stk_r_valid = s_rv[1]; assign bus.tcdm_r_valid = s_rv[2];
   assign bus.per_r_data = s_rd[0]; assign bus.stk_r_data = s_rd[1]; assign bus.tcdm_r_data = s_rd[2];
   assign s_req = {bus.tcdm_req, bus.stk_req, bus.per_req};
   assign s_wen = {bus.tcdm_wen, bus.stk_wen, bus.per_wen};
   assign s_add[0] = bus.per_add; assign s_add[1] = bus.stk_add; assign s_add[2] = bus.tcdm_add;
   assign s_dat[0] = bus.per_data; assign s_dat[1] = bus.stk_data; assign s_dat[2] = bus.tcdm_data;
   assign s_be[0] = bus.per_be; assign s_be[1] = bus.stk_be; assign s_be[2] = bus.tcdm_be;

   int errors = 0, checks = 0;
   logic [31:0] exp_q [$];
   logic [31:0] pend [3][$];
   logic [31:0] cur_rdata;
   logic        slv_en = 1'b0, acc_flag = 1'b0, local_due = 1'b0;
   int          m_out = 0, m_cur = 0, et;
   logic        resp, stall, acc;
`ifdef CORE_DATA_DEMUX_STDOUT_EN
   logic        so_due = 1'b0, m_ex_v = 1'b0;
   logic [7:0]  so_exp = 8'h0;
   logic [31:0] m_ex_c = 32'h0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
      end
   endtask

   // target chosen purely from the address rules: periph bit, stack window, mailbox, else tcdm
   function automatic int exp_tgt(input logic [31:0] a);
      if (a[20]) return 0;
      if (a[31:24] == 8'h00) return 1;
`ifdef CORE_DATA_DEMUX_STDOUT_EN
      if (a == STDOUT_A || a == EXIT_A) return 3;
`endif
      return 2;
   endfunction

   task automatic issue();
      int k = $urandom_range(0, 9);
      logic [31:0] a = $urandom;
      bus.data_addr  = k < 3 ? a | 32'h0010_0000 : k < 5 ? a & 32'h00EF_FFFF :
                       k < 8 ? (a | 32'h0100_0000) & 32'hFFEF_FFFF : k == 8 ? STDOUT_A : EXIT_A;
      bus.data_we    = 1'($urandom);
      bus.data_be    = 4'($urandom);
      bus.data_wdata = $urandom;
      cur_rdata      = $urandom;
      bus.data_req   = 1'b1;
   endtask

   // behavioural slaves: in-order responses from their pending queues after a random delay
   initial begin
      for (int t = 0; t < 3; t++) s_rd[t] = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (slv_en)
            for (int t = 0; t < 3; t++) begin
               s_gnt[t] = $urandom_range(0, 3) != 0;
               s_rv[t]  = pend[t].size() != 0 && $urandom_range(0, 2) != 0;
               s_rd[t]  = s_rv[t] ? pend[t][0] : $urandom;
            end
      end
   end

   // monitor: model of outstanding requests, routing checks and response scoreboard
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete();
         for (int t = 0; t < 3; t++) pend[t].delete();
         m_out = 0; m_cur = 0; local_due = 1'b0; acc_flag = 1'b0;
`ifdef CORE_DATA_DEMUX_STDOUT_EN
         so_due = 1'b0; m_ex_v = 1'b0; m_ex_c = 32'h0;
`endif
         continue;
      end
      resp = m_out != 0 && (m_cur == 3 ? local_due : s_rv[m_cur]);
      chk("rvalid", 32'(bus.data_rvalid), 32'(resp));
      if (bus.data_rvalid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rvalid_unexpected: got rvalid with empty scoreboard at %0t", $time);
         end else chk("rdata", bus.data_rdata, exp_q.pop_front());
      end
`ifdef CORE_DATA_DEMUX_STDOUT_EN
      chk("stdout_valid", 32'(so_v), 32'(so_due));
      if (so_due) chk("stdout_char", 32'(so_c), 32'(so_exp));
      chk("exit", {ex_c[30:0], ex_v}, {m_ex_c[30:0], m_ex_v});
`else
      chk("mbox_off", ex_c | 32'({so_v, so_c, ex_v}), 32'h0);
`endif
      et    = exp_tgt(bus.data_addr);
      stall = m_out == MAXO || (m_out != 0 && et != m_cur);
      if (!bus.data_req || stall) chk("blocked", 32'({bus.data_gnt, s_req}), 32'h0);
      else if (et == 3) chk("local", 32'({bus.data_gnt, s_req}), 32'h8);
      else chk("route", 32'({bus.data_gnt, s_req}), 32'({s_gnt[et], 3'(1 << et)}));
      for (int t = 0; t < 3; t++)
         if (s_req[t]) begin
            chk("fwd_add", s_add[t], t == 2 ? bus.data_addr & 32'h00FF_FFFF : bus.data_addr);
            chk("fwd_ctl", 32'({s_wen[t], s_be[t]}), 32'({~bus.data_we, bus.data_be}));
            chk("fwd_data", s_dat[t], bus.data_wdata);
         end
      for (int t = 0; t < 3; t++) if (s_rv[t] && pend[t].size() != 0) void'(pend[t].pop_front());
      for (int t = 0; t < 3; t++) if (s_req[t] && s_gnt[t]) pend[t].push_back(cur_rdata);
      acc = bus.data_req & bus.data_gnt;
      if (acc) exp_q.push_back(et == 3 ? 32'h0 : cur_rdata);
`ifdef CORE_DATA_DEMUX_STDOUT_EN
      so_due = acc && et == 3 && bus.data_we && bus.data_addr == STDOUT_A;
      so_exp = bus.data_wdata[7:0];
      if (acc && et == 3 && bus.data_we && bus.data_addr == EXIT_A) begin
         m_ex_v = 1'b1;
         m_ex_c = bus.data_wdata;
      end
`endif
      local_due = acc && et == 3;
      m_out     = m_out + int'(acc) - int'(resp);
      if (acc) m_cur = et;
      acc_flag  = acc;
   end

   initial begin
      rst_n = 1'b0;
      bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_be = 4'h0;
      bus.data_addr = 32'h0; bus.data_wdata = 32'h0; cur_rdata = 32'h0;
      s_gnt = 3'b0; s_rv = 3'b0;
      #12;
      chk("reset_flags", 32'({bus.data_gnt, bus.data_rvalid, prot_err, s_req, so_v, ex_v}), 32'h0);
      chk("reset_rdata", bus.data_rdata | ex_c, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      slv_en = 1'b1;
      repeat (3000) begin
         @(posedge clk); #1;
         if (!bus.data_req || acc_flag) begin
            if ($urandom_range(0, 3) != 0) issue(); else bus.data_req = 1'b0;
         end
      end
      @(posedge clk); #1 bus.data_req = 1'b0;
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
      chk("drain", 32'(exp_q.size()), 32'h0);
      @(posedge clk); #1 slv_en = 1'b0; s_gnt = 3'b0; s_rv = 3'b0;
      @(negedge clk) chk("no_proto_err", 32'(prot_err), 32'h0);
      // unsolicited stack response while idle
      @(posedge clk); #1 s_rv = 3'b010;
      @(posedge clk); #1 s_rv = 3'b000;
      @(negedge clk) chk("proto_err_set", 32'(prot_err), 32'h1);
      repeat (3) @(posedge clk);
      #1 chk("proto_err_sticky", 32'(prot_err), 32'h1);
      // one tcdm read in flight, then asynchronous reset
      @(posedge clk); #1 s_gnt = 3'b100; bus.data_addr = 32'h1000_0004; bus.data_we = 1'b0; bus.data_req = 1'b1;
      cur_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1 bus.data_req = 1'b0; s_gnt = 3'b000;
      #2 rst_n = 1'b0; bus.data_req = 1'b1;
      #1 chk("async_reset", 32'({bus.data_gnt, bus.data_rvalid, prot_err, s_req, so_v, ex_v}), 32'h0);
      @(negedge clk) rst_n = 1'b1; bus.data_req = 1'b0;
      @(posedge clk); #1 s_rv = 3'b100;
      @(posedge clk); #1 s_rv = 3'b000;
      @(negedge clk) chk("late_rvalid_err", 32'(prot_err), 32'h1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
